// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared fetch-stage types and constants
package if_fetch_stage_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SKID, KILL} fetch_state_e;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;
    localparam int DEF_PC_STEP = 4;
endpackage

// File: rtl/if_fetch_stage_skid.sv
// if_skid_reg: one-entry {instr, pc} holding buffer with load/clear/valid
module if_skid_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [N-1:0] d_instr,
    input  logic [N-1:0] d_pc,
    output logic [N-1:0] q_instr,
    output logic [N-1:0] q_pc,
    output logic         valid
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid   <= 1'b0;
            q_instr <= N'(BUBBLE_INSTR);
            q_pc    <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            q_instr <= d_instr;
            q_pc    <= d_pc;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and imem req/ack fetcher feeding IF/ID with skid and redirect
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           PC_STEP  = DEF_PC_STEP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr_out,
    output logic [N-1:0] pc_out,
    output logic         instr_valid,
    output logic         flush_out
);
    fetch_state_e state, nstate;
    logic [N-1:0] pc, req_addr, skid_instr, skid_pc;
    logic free, issue, pend, cap_mem, cap_skid, skid_load, skid_valid;

    assign flush_out = redirect_valid;

    always_comb begin
        free      = !instr_valid || !stall;
        imem_req  = !rst && (state == WAIT || state == KILL || (state == FETCH && free));
        imem_addr = (state == WAIT || state == KILL) ? req_addr : pc;
        issue     = state == FETCH && imem_req;
        pend      = (issue || state == WAIT || state == KILL) && !imem_ack;
        cap_mem   = imem_ack && (issue || (state == WAIT && free));
        cap_skid  = state == SKID && free && skid_valid;
        skid_load = state == WAIT && imem_ack && !free && !redirect_valid;
        nstate    = redirect_valid   ? (pend ? KILL : FETCH) :
                    state == IDLE    ? FETCH :
                    pend             ? (state == FETCH ? WAIT : state) :
                    state == WAIT    ? (free ? FETCH : SKID) :
                    state == SKID    ? (free ? FETCH : SKID) : FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            instr_out   <= N'(BUBBLE_INSTR);
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= nstate;
            pc    <= redirect_valid ? (redirect_pc & ~N'(3)) : issue ? pc + N'(PC_STEP) : pc;
            if (issue)
                req_addr <= pc;
            if (redirect_valid) begin
                instr_valid <= 1'b0;
                instr_out   <= N'(BUBBLE_INSTR);
            end else if (cap_mem) begin
                instr_valid <= 1'b1;
                instr_out   <= imem_rdata;
                pc_out      <= state == FETCH ? pc : req_addr;
            end else if (cap_skid) begin
                instr_valid <= 1'b1;
                instr_out   <= skid_instr;
                pc_out      <= skid_pc;
            end else if (free) begin
                instr_valid <= 1'b0;
                instr_out   <= N'(BUBBLE_INSTR);
            end
        end
    end

    if_skid_reg #(.N(N)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (redirect_valid),
        .d_instr (imem_rdata),
        .d_pc    (req_addr),
        .q_instr (skid_instr),
        .q_pc    (skid_pc),
        .valid   (skid_valid)
    );
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: random-stimulus bench with a stream-level fetch model
module tb_if_fetch_stage;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic clk = 0, rst, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_out;
    logic imem_req, imem_ack, instr_valid, flush_out;
    logic r1_req, r1_valid, r1_flush;
    logic [31:0] r1_addr, r1_instr, r1_pc;
    logic zero = 1'b0;
    logic [31:0] zero32 = '0;
    int total = 0, bad = 0;
    int wcnt = 0, dly = 0, dmode = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
        .pc_out(pc_out), .instr_valid(instr_valid), .flush_out(flush_out)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst), .stall(zero), .redirect_valid(zero),
        .redirect_pc(zero32), .imem_req(r1_req), .imem_addr(r1_addr),
        .imem_ack(r1_req), .imem_rdata(r1_addr ^ K), .instr_out(r1_instr),
        .pc_out(r1_pc), .instr_valid(r1_valid), .flush_out(r1_flush)
    );

    assign imem_ack   = imem_req && (wcnt >= dly);
    assign imem_rdata = imem_addr ^ K;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) begin
            wcnt <= 0;
            dly  <= dmode == 2 ? int'($urandom_range(0, 3)) : dmode == 1 ? 3 : 0;
        end else
            wcnt <= wcnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s act=%h want=%h t=%0t", nm, act, want, $time);
        end
    endtask

    logic p_rst = 1, p_stall = 0, p_red = 0, p_valid = 0, p_req = 0, p_ack = 0;
    logic [31:0] p_rpc = 0, p_instr = 0, p_pc = 0, p_addr = 0, exp_pc = 0;
    int idle = 0, nd = 0;

    always @(negedge clk) begin
        chk("flush", flush_out, redirect_valid);
        if (p_rst) begin
            exp_pc = 32'h0;
            idle = 0;
        end else if (p_red) begin
            chk("redir_valid", instr_valid, 0);
            chk("redir_instr", instr_out, 0);
            exp_pc = p_rpc & ~32'h3;
            idle = 0;
        end else if (p_valid && p_stall) begin
            chk("hold_valid", instr_valid, 1);
            chk("hold_instr", instr_out, p_instr);
            chk("hold_pc", pc_out, p_pc);
            idle = 0;
        end else if (instr_valid) begin
            chk("stream_pc", pc_out, exp_pc);
            chk("stream_instr", instr_out, exp_pc ^ K);
            exp_pc += 4;
            nd++;
            idle = 0;
        end else begin
            chk("bubble", instr_out, 0);
            idle++;
        end
        if (p_req && !p_ack && !p_rst && !rst) begin
            chk("addr_req_held", imem_req, 1);
            chk("addr_stable", imem_addr, p_addr);
        end
        if (imem_req) chk("addr_align", imem_addr & 32'h3, 0);
        chk("liveness", idle > 60, 0);
        if (idle > 60) idle = 0;
        p_rst = rst; p_stall = stall; p_red = redirect_valid; p_rpc = redirect_pc;
        p_valid = instr_valid; p_instr = instr_out; p_pc = pc_out;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        logic [31:0] ka, hp;
        rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_u1_valid", r1_valid, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("idle_req", imem_req, 0);
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_valid", instr_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_valid", instr_valid, 1);
            chk("run_pc", pc_out, 32'(4 * i));
            chk("run_instr", instr_out, 32'(4 * i) ^ K);
            chk("wrap_pc", r1_pc, 32'hFFFF_FFF8 + 32'(4 * i));
            chk("wrap_instr", r1_instr, (32'hFFFF_FFF8 + 32'(4 * i)) ^ K);
        end
        chk("u1_flush", r1_flush, 0);
        dmode = 1;
        repeat (30) @(posedge clk);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            found = imem_req && !imem_ack;
        end
        chk("find_outstanding", found, 1);
        ka = imem_addr;
        redirect_valid = 1; redirect_pc = 32'h0000_0103;
        #1 chk("flush_same_cycle", flush_out, 1);
        @(posedge clk); #1 redirect_valid = 0;
        @(negedge clk);
        chk("post_redir_valid", instr_valid, 0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = imem_req && imem_addr != ka;
        end
        chk("find_new_req", found, 1);
        chk("redir_target_addr", imem_addr, 32'h0000_0100);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            found = instr_valid;
        end
        chk("find_valid", found, 1);
        hp = pc_out;
        stall = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_req_off", imem_req, 0);
        chk("stall_valid", instr_valid, 1);
        chk("stall_pc_hold", pc_out, hp);
        @(posedge clk); #1 stall = 0;
        @(negedge clk);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            found = imem_req && !imem_ack;
        end
        chk("find_wait", found, 1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("rst_wait_req", imem_req, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_wait_req_after", imem_req, 0);
        chk("rst_wait_valid", instr_valid, 0);
        dmode = 2;
        nd = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            stall = ($urandom % 10) < 3;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc = $urandom & 32'h0000_FFFF;
        end
        @(posedge clk); #1 stall = 0; redirect_valid = 0;
        repeat (10) @(posedge clk);
        chk("deliveries", nd > 300, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
